// File: rtl/qic117_burst_cmd_engine.sv
`timescale 1ns/1ps
// QIC-117 STEP burst counter and command assembler; one cmd or err strobe per sequence.
// Latency: strobe BURST_TMO+1 clocks after the last sampled step (PARAM_WAIT+1 after entering wait on a missing parameter).
// Backpressure: none; strobes are fire-and-forget, code/param/err fields hold until the next strobe of their kind.
module qic117_burst_cmd_engine #(
    parameter int                CODE_W     = 6,
    parameter int                MAX_CODE   = 48,
    parameter int                PARAM_W    = 8,
    parameter int                MAX_PARAM  = 255,
    parameter int                TMO_W      = 24,
    parameter logic [TMO_W-1:0]  BURST_TMO  = TMO_W'(100),
    parameter logic [TMO_W-1:0]  PARAM_WAIT = TMO_W'(1000)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                step_pulse,
    output logic                cmd_valid,
    output logic [CODE_W-1:0]   cmd_code,
    output logic [PARAM_W-1:0]  cmd_param,
    output logic                cmd_has_param,
    output logic                err_valid,
    output logic [1:0]          err_code,
    output logic                busy,
    output logic [PARAM_W:0]    burst_count
);
    localparam int                CW          = PARAM_W + 1;
    localparam logic [CW-1:0]     CMD_SAT     = CW'(MAX_CODE + 1);
    localparam logic [CW-1:0]     PARAM_SAT   = '1;
    localparam logic [CW-1:0]     MAX_CODE_C  = CW'(MAX_CODE);
    localparam logic [CW-1:0]     MAX_PARAM_C = CW'(MAX_PARAM);
    localparam logic [CW-1:0]     NIB_MAX     = CW'(15);
    localparam logic [TMO_W-1:0]  BURST_LAST  = BURST_TMO - TMO_W'(1);
    localparam logic [TMO_W-1:0]  WAIT_LAST   = PARAM_WAIT - TMO_W'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD_BURST, S_PARAM_WAIT, S_PARAM_BURST, S_FINISH
    } state_t;

    state_t              state_q, state_n;
    logic [CW-1:0]       cnt_q, cnt_n;
    logic [TMO_W-1:0]    tmo_q, tmo_n;
    logic [CODE_W-1:0]   code_q, code_n;
    logic [PARAM_W-1:0]  param_q, param_n;
    logic                nibble_q, nibble_n;
    logic                nib_hi_q, nib_hi_n;
    logic                in_param_q, in_param_n;
    logic                missing_q, missing_n;

    logic                cmd_valid_n, cmd_has_param_n, err_valid_n;
    logic [CODE_W-1:0]   cmd_code_n;
    logic [PARAM_W-1:0]  cmd_param_n;
    logic [1:0]          err_code_n;

    logic [CW-1:0]       value;
    logic [CW-1:0]       sat;
    logic                two_param, one_param, range_bad;

    assign busy        = (state_q != S_IDLE);
    assign burst_count = cnt_q;

    always_comb begin
        state_n         = state_q;
        cnt_n           = cnt_q;
        tmo_n           = tmo_q;
        code_n          = code_q;
        param_n         = param_q;
        nibble_n        = nibble_q;
        nib_hi_n        = nib_hi_q;
        in_param_n      = in_param_q;
        missing_n       = missing_q;
        cmd_valid_n     = 1'b0;
        cmd_code_n      = cmd_code;
        cmd_param_n     = cmd_param;
        cmd_has_param_n = cmd_has_param;
        err_valid_n     = 1'b0;
        err_code_n      = err_code;

        value     = cnt_q - CW'(2);
        sat       = (state_q == S_CMD_BURST) ? CMD_SAT : PARAM_SAT;
        two_param = (cnt_q == CW'(14)) || (cnt_q == CW'(15));
        one_param = (cnt_q == CW'(18)) || (cnt_q == CW'(19)) ||
                    (cnt_q == CW'(33)) || (cnt_q == CW'(45));
        range_bad = (cnt_q < CW'(2)) ||
                    (nibble_q && (value > NIB_MAX)) ||
                    (!nibble_q && (value > MAX_PARAM_C));

        if (!enable) begin
            state_n    = S_IDLE;
            cnt_n      = '0;
            tmo_n      = '0;
            nibble_n   = 1'b0;
            nib_hi_n   = 1'b0;
            in_param_n = 1'b0;
            missing_n  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (step_pulse) begin
                        state_n    = S_CMD_BURST;
                        cnt_n      = CW'(1);
                        tmo_n      = '0;
                        in_param_n = 1'b0;
                        missing_n  = 1'b0;
                    end
                end
                // A step coinciding with the last idle cycle still extends the burst.
                S_CMD_BURST, S_PARAM_BURST: begin
                    if (step_pulse) begin
                        if (cnt_q != sat) cnt_n = cnt_q + CW'(1);
                        tmo_n = '0;
                    end else if (tmo_q == BURST_LAST) begin
                        state_n = S_FINISH;
                    end else begin
                        tmo_n = tmo_q + TMO_W'(1);
                    end
                end
                S_PARAM_WAIT: begin
                    if (step_pulse) begin
                        state_n    = S_PARAM_BURST;
                        cnt_n      = CW'(1);
                        tmo_n      = '0;
                        in_param_n = 1'b1;
                    end else if (tmo_q == WAIT_LAST) begin
                        state_n   = S_FINISH;
                        missing_n = 1'b1;
                    end else begin
                        tmo_n = tmo_q + TMO_W'(1);
                    end
                end
                // One-cycle decision point so every strobe leaves a registered output.
                S_FINISH: begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                    tmo_n   = '0;
                    if (missing_q) begin
                        err_valid_n = 1'b1;
                        err_code_n  = 2'd2;
                    end else if (!in_param_q) begin
                        if (cnt_q > MAX_CODE_C) begin
                            err_valid_n = 1'b1;
                            err_code_n  = 2'd1;
                        end else if (two_param || one_param) begin
                            state_n  = S_PARAM_WAIT;
                            code_n   = cnt_q[CODE_W-1:0];
                            param_n  = '0;
                            nibble_n = two_param;
                            nib_hi_n = 1'b0;
                        end else begin
                            cmd_valid_n     = 1'b1;
                            cmd_code_n      = cnt_q[CODE_W-1:0];
                            cmd_param_n     = '0;
                            cmd_has_param_n = 1'b0;
                        end
                    end else if (range_bad) begin
                        err_valid_n = 1'b1;
                        err_code_n  = 2'd3;
                    end else if (nibble_q && !nib_hi_q) begin
                        state_n      = S_PARAM_WAIT;
                        param_n[3:0] = value[3:0];
                        nib_hi_n     = 1'b1;
                    end else begin
                        cmd_valid_n     = 1'b1;
                        cmd_code_n      = code_q;
                        cmd_param_n     = nibble_q ? PARAM_W'({value[3:0], param_q[3:0]})
                                                   : value[PARAM_W-1:0];
                        cmd_has_param_n = 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            tmo_q         <= '0;
            code_q        <= '0;
            param_q       <= '0;
            nibble_q      <= 1'b0;
            nib_hi_q      <= 1'b0;
            in_param_q    <= 1'b0;
            missing_q     <= 1'b0;
            cmd_valid     <= 1'b0;
            cmd_code      <= '0;
            cmd_param     <= '0;
            cmd_has_param <= 1'b0;
            err_valid     <= 1'b0;
            err_code      <= '0;
        end else begin
            state_q       <= state_n;
            cnt_q         <= cnt_n;
            tmo_q         <= tmo_n;
            code_q        <= code_n;
            param_q       <= param_n;
            nibble_q      <= nibble_n;
            nib_hi_q      <= nib_hi_n;
            in_param_q    <= in_param_n;
            missing_q     <= missing_n;
            cmd_valid     <= cmd_valid_n;
            cmd_code      <= cmd_code_n;
            cmd_param     <= cmd_param_n;
            cmd_has_param <= cmd_has_param_n;
            err_valid     <= err_valid_n;
            err_code      <= err_code_n;
        end
    end
endmodule
